// File: rtl/mer_calculator_if.sv
// mer_calculator_if
//   Groups the accumulator inputs and result outputs of mer_calculator.
//   master : upstream MER circuit / monitor side (drives strobes and accumulators,
//            receives clear and results)
//   slave  : mer_calculator
//
//   sym_clk_ena                one-cycle symbol strobe
//   meas_enable                1 = run windowed measurement
//   mapper_out_power[39:0]     signal-power accumulator P
//   accumulated_squared_error  squared-error accumulator E [29:0]
//   accumulated_error[35:0]    DC-error accumulator, passed through
//   reference_level[17:0]      signed reference level, passed through
//   clear_accumulator          window-boundary clear to the MER circuit
//   mer_db[11:0]               MER in dB, u8.4
//   mer_ratio[23:0]            saturated P/E quotient, u16.8
//   dc_error_latched[35:0]     accumulated_error captured at window end
//   ref_level_latched[17:0]    reference_level captured at window end
//   mer_valid                  one-cycle result strobe
//   div_by_zero                last result had E == 0
//   busy                       divider/log pipeline active
//   mer_min[11:0]              running minimum of mer_db (optional)
interface mer_calculator_if;
    logic               sym_clk_ena;
    logic               meas_enable;
    logic [39:0]        mapper_out_power;
    logic [29:0]        accumulated_squared_error;
    logic [35:0]        accumulated_error;
    logic signed [17:0] reference_level;
    logic               clear_accumulator;
    logic [11:0]        mer_db;
    logic [23:0]        mer_ratio;
    logic [35:0]        dc_error_latched;
    logic signed [17:0] ref_level_latched;
    logic               mer_valid;
    logic               div_by_zero;
    logic               busy;
    logic [11:0]        mer_min;

    modport master (
        output sym_clk_ena, meas_enable, mapper_out_power,
               accumulated_squared_error, accumulated_error, reference_level,
        input  clear_accumulator, mer_db, mer_ratio, dc_error_latched,
               ref_level_latched, mer_valid, div_by_zero, busy, mer_min
    );

    modport slave (
        input  sym_clk_ena, meas_enable, mapper_out_power,
               accumulated_squared_error, accumulated_error, reference_level,
        output clear_accumulator, mer_db, mer_ratio, dc_error_latched,
               ref_level_latched, mer_valid, div_by_zero, busy, mer_min
    );
endinterface

// File: rtl/mer_calculator.sv
// mer_calculator
//   Owns the MER measurement window: counts symbols, pulses clear_accumulator at
//   each window boundary while capturing the pre-clear accumulators, then computes
//   MER = P / E with a 48-cycle restoring divider and converts the ratio to dB
//   through a leading-one + 16-entry log2 table. One result per window, presented
//   51 cycles after the clear pulse.
//
// Ports
//   sys_clk   system clock
//   reset     synchronous active-low reset
//   bus       mer_calculator_if.slave (accumulators in, clear and results out)
//
// Parameters
//   WINDOW_LOG2  window length = 2^WINDOW_LOG2 symbols (6..24)
//   DB_OFFSET    signed offset in u8.4 units added to mer_db
//
// Build option
//   MER_MIN_TRACK_EN  when defined, mer_min tracks the smallest mer_db since
//                     reset; otherwise mer_min is tied to 12'hFFF.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a non-flush window clear
// DIVIDE | restoring divide, one quotient bit per cycle (cycles 1..48)
// LOG1   | leading-one detect + table lookup -> log2_q4 (cycle 49)
// LOG2   | scale log2 to dB, clamp, load result registers (cycle 50)
// DONE   | results valid, mer_valid high (cycle 51)
module mer_calculator #(
    parameter int WINDOW_LOG2 = 16,
    parameter int DB_OFFSET   = 0
) (
    input  logic            sys_clk,
    input  logic            reset,
    mer_calculator_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_LOG1,
        ST_LOG2,
        ST_DONE
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] COUNT_LAST = '1;
    localparam logic signed [20:0]     DB_OFF     = 21'(DB_OFFSET);

    // window counter
    logic [WINDOW_LOG2-1:0] sym_count;
    logic                   clear_acc;
    logic                   clear_flush;
    logic                   flush_pending;

    // datapath state
    state_t             state;
    logic [5:0]         div_timer;
    logic [47:0]        dq;
    logic [29:0]        rem;
    logic [29:0]        divisor;
    logic               e_zero;
    logic [35:0]        dc_hold;
    logic signed [17:0] ref_hold;
    logic signed [10:0] log2_q4;
    logic               q_zero;

    // registered outputs
    logic [11:0]        mer_db_r;
    logic [23:0]        mer_ratio_r;
    logic [35:0]        dc_r;
    logic signed [17:0] ref_r;
    logic               valid_r;
    logic               dz_r;
    logic               busy_r;

    // combinational helpers
    logic [30:0]        trial;
    logic               quo_bit;
    logic [29:0]        rem_next;
    logic [23:0]        q_sat;
    logic [4:0]         lead_k;
    logic [3:0]         mant;
    logic [4:0]         lut_val;
    logic signed [10:0] log2_next;
    logic signed [20:0] log2_ext;
    logic signed [20:0] prod;
    logic signed [20:0] scaled;
    logic signed [20:0] db_sum;
    logic [11:0]        db_next;

    // Symbol counter and window clear. The first strobe after meas_enable rises
    // only flushes the upstream accumulators, since they were integrating while
    // the window was not running.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            sym_count     <= '0;
            clear_acc     <= 1'b0;
            clear_flush   <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            clear_acc   <= 1'b0;
            clear_flush <= 1'b0;
            if (!bus.meas_enable) begin
                sym_count     <= '0;
                flush_pending <= 1'b1;
            end else if (bus.sym_clk_ena) begin
                if (flush_pending) begin
                    sym_count     <= '0;
                    clear_acc     <= 1'b1;
                    clear_flush   <= 1'b1;
                    flush_pending <= 1'b0;
                end else if (sym_count == COUNT_LAST) begin
                    sym_count <= '0;
                    clear_acc <= 1'b1;
                end else begin
                    sym_count <= sym_count + WINDOW_LOG2'(1);
                end
            end
        end
    end

    // Restoring divide step: shift the next numerator bit into the remainder and
    // subtract the divisor when it fits. The quotient shifts into dq from the
    // right as the numerator shifts out of the left.
    assign trial    = {rem, dq[47]};
    assign quo_bit  = (trial >= {1'b0, divisor});
    assign rem_next = quo_bit ? 30'(trial - {1'b0, divisor}) : trial[29:0];

    always_comb begin
        if (e_zero || (|dq[47:24])) begin
            q_sat = 24'hFF_FFFF;
        end else begin
            q_sat = dq[23:0];
        end
    end

    always_comb begin
        lead_k = '0;
        for (int i = 0; i < 24; i++) begin
            if (q_sat[i]) begin
                lead_k = 5'(i);
            end
        end
    end

    // Normalise so the leading one sits at bit 23; the next four bits are the
    // mantissa (zero-padded for small k).
    assign mant = 4'((q_sat << (5'd23 - lead_k)) >> 19);

    // round(16 * log2(1 + m/16))
    always_comb begin
        case (mant)
            4'd0:    lut_val = 5'd0;
            4'd1:    lut_val = 5'd1;
            4'd2:    lut_val = 5'd3;
            4'd3:    lut_val = 5'd4;
            4'd4:    lut_val = 5'd5;
            4'd5:    lut_val = 5'd6;
            4'd6:    lut_val = 5'd7;
            4'd7:    lut_val = 5'd8;
            4'd8:    lut_val = 5'd9;
            4'd9:    lut_val = 5'd10;
            4'd10:   lut_val = 5'd11;
            4'd11:   lut_val = 5'd12;
            4'd12:   lut_val = 5'd13;
            4'd13:   lut_val = 5'd14;
            4'd14:   lut_val = 5'd15;
            default: lut_val = 5'd15;
        endcase
    end

    // (k - 8) * 16 + LUT[m]: the ratio is u16.8, so bit 8 is 2^0.
    assign log2_next = $signed({2'b00, lead_k, 4'b0000}) - 11'sd128
                     + $signed({6'b000000, lut_val});

    // dB = 10*log10(2) * log2 ~= 771/256 * log2, all in q4.
    always_comb begin
        log2_ext = {{10{log2_q4[10]}}, log2_q4};
        prod     = log2_ext * 21'sd771;
        scaled   = prod >>> 8;
        db_sum   = scaled + DB_OFF;
        if (q_zero || (db_sum < 21'sd0)) begin
            db_next = '0;
        end else if (db_sum > 21'sd4095) begin
            db_next = 12'hFFF;
        end else begin
            db_next = db_sum[11:0];
        end
    end

    // Accumulators are captured only on the clear that starts a computation;
    // a clear seen while busy still reaches the MER circuit but leaves the
    // in-flight operands untouched.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            div_timer   <= '0;
            dq          <= '0;
            rem         <= '0;
            divisor     <= '0;
            e_zero      <= 1'b0;
            dc_hold     <= '0;
            ref_hold    <= '0;
            log2_q4     <= '0;
            q_zero      <= 1'b0;
            mer_db_r    <= '0;
            mer_ratio_r <= '0;
            dc_r        <= '0;
            ref_r       <= '0;
            valid_r     <= 1'b0;
            dz_r        <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_acc && !clear_flush) begin
                        dq        <= {bus.mapper_out_power, 8'h00};
                        rem       <= '0;
                        divisor   <= bus.accumulated_squared_error;
                        e_zero    <= (bus.accumulated_squared_error == '0);
                        dc_hold   <= bus.accumulated_error;
                        ref_hold  <= bus.reference_level;
                        div_timer <= 6'd47;
                        busy_r    <= 1'b1;
                        state     <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    // E == 0 still spends the full 48 cycles so latency is fixed
                    if (!e_zero) begin
                        dq  <= {dq[46:0], quo_bit};
                        rem <= rem_next;
                    end
                    if (div_timer == 6'd0) begin
                        state <= ST_LOG1;
                    end else begin
                        div_timer <= div_timer - 6'd1;
                    end
                end
                ST_LOG1: begin
                    log2_q4 <= log2_next;
                    q_zero  <= (q_sat == 24'd0);
                    state   <= ST_LOG2;
                end
                ST_LOG2: begin
                    mer_db_r    <= db_next;
                    mer_ratio_r <= q_sat;
                    dc_r        <= dc_hold;
                    ref_r       <= ref_hold;
                    dz_r        <= e_zero;
                    valid_r     <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MER_MIN_TRACK_EN
    logic [11:0] min_r;

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            min_r <= 12'hFFF;
        end else if ((state == ST_LOG2) && (db_next < min_r)) begin
            min_r <= db_next;
        end
    end

    assign bus.mer_min = min_r;
`else
    assign bus.mer_min = 12'hFFF;
`endif

    assign bus.clear_accumulator = clear_acc;
    assign bus.mer_db            = mer_db_r;
    assign bus.mer_ratio         = mer_ratio_r;
    assign bus.dc_error_latched  = dc_r;
    assign bus.ref_level_latched = ref_r;
    assign bus.mer_valid         = valid_r;
    assign bus.div_by_zero       = dz_r;
    assign bus.busy              = busy_r;

endmodule

// File: tb/tb_mer_calculator.sv
// Self-checking bench for mer_calculator with WINDOW_LOG2 = 6 and a symbol
// strobe every 4 cycles. Expected results are pushed at each computing window
// clear; a monitor pops and compares on every mer_valid.
module tb_mer_calculator;

    logic sys_clk = 1'b0;
    logic reset;

    mer_calculator_if bus ();

    mer_calculator #(
        .WINDOW_LOG2(6),
        .DB_OFFSET  (0)
    ) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [11:0]        db;
        logic [23:0]        ratio;
        logic               dz;
        logic [35:0]        dc;
        logic signed [17:0] rl;
        logic [11:0]        mn;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_min = 12'hFFF;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // symbol strobe: one cycle high every 4 cycles
    initial begin
        int ph;
        ph = 0;
        bus.sym_clk_ena = 1'b0;
        forever begin
            @(negedge sys_clk);
            bus.sym_clk_ena = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    // monitor: clear spacing/width, result scoreboard, latency, busy
    int cyc            = 0;
    int last_clear_cyc = 0;
    int strobes        = 0;
    bit first_clear    = 1'b1;
    bit prev_busy      = 1'b0;
    bit prev_clear     = 1'b0;

    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        cyc++;
        if (!reset) begin
            strobes = 0;
        end else if (!bus.meas_enable) begin
            strobes     = 0;
            first_clear = 1'b1;
        end else if (bus.sym_clk_ena) begin
            strobes++;
        end
        if (bus.clear_accumulator) begin
            chk("clear_width", 64'(prev_clear), 64'd0);
            if (!first_clear) begin
                chk("clear_spacing", 64'(strobes), 64'd64);
            end
            first_clear    = 1'b0;
            strobes        = 0;
            last_clear_cyc = cyc;
        end
        if (bus.mer_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got mer_valid=1 want no pending result");
            end else begin
                e = sb.pop_front();
                chk("mer_db", 64'(bus.mer_db), 64'(e.db));
                chk("mer_ratio", 64'(bus.mer_ratio), 64'(e.ratio));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                chk("dc_latched", 64'(bus.dc_error_latched), 64'(e.dc));
                chk("ref_latched", 64'(bus.ref_level_latched), 64'(e.rl));
                chk("mer_min", 64'(bus.mer_min), 64'(e.mn));
                chk("latency", 64'(cyc - last_clear_cyc), 64'd51);
                chk("busy_before_done", 64'(prev_busy), 64'd1);
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
        prev_busy  = bus.busy;
        prev_clear = bus.clear_accumulator;
    end

    task automatic wait_clear();
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (bus.clear_accumulator) begin
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL clear_timeout got no clear_accumulator want one within 400 cycles");
    endtask

    task automatic set_inputs(input logic [39:0] p, input logic [29:0] e,
                              input logic [35:0] dc, input logic signed [17:0] rl);
        bus.mapper_out_power          = p;
        bus.accumulated_squared_error = e;
        bus.accumulated_error         = dc;
        bus.reference_level           = rl;
    endtask

    task automatic window(input logic [39:0] p, input logic [29:0] e,
                          input logic [35:0] dc, input logic signed [17:0] rl,
                          input logic [11:0] db, input logic [23:0] ratio, input logic dz);
        exp_t x;
        set_inputs(p, e, dc, rl);
        wait_clear();
`ifdef MER_MIN_TRACK_EN
        if (db < exp_min) exp_min = db;
`endif
        x.db    = db;
        x.ratio = ratio;
        x.dz    = dz;
        x.dc    = dc;
        x.rl    = rl;
        x.mn    = exp_min;
        sb.push_back(x);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_db"}, 64'(bus.mer_db), 64'd0);
        chk({tag, "_ratio"}, 64'(bus.mer_ratio), 64'd0);
        chk({tag, "_dc"}, 64'(bus.dc_error_latched), 64'd0);
        chk({tag, "_ref"}, 64'(bus.ref_level_latched), 64'd0);
        chk({tag, "_flags"}, 64'({bus.clear_accumulator, bus.mer_valid, bus.div_by_zero, bus.busy}), 64'd0);
        chk({tag, "_min"}, 64'(bus.mer_min), 64'h0FFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        bus.meas_enable = 1'b0;
        set_inputs(40'd0, 30'd0, 36'd0, 18'sd0);
        repeat (3) @(negedge sys_clk);
        chk_reset_state("rst_init");
        reset = 1'b1;
        @(negedge sys_clk);

        // enable: first strobe is a flush with no result
        bus.meas_enable = 1'b1;
        wait_clear();
        repeat (2) @(negedge sys_clk);

        window(40'd100000, 30'd1000, 36'h1_2345_6789, 18'sd1234, 12'd319, 24'h006400, 1'b0);
        window(40'd1000, 30'd1000, 36'hF_0000_0001, -18'sd5, 12'd0, 24'h000100, 1'b0);
        window(40'd100000, 30'd1000, 36'h0_0000_0000, -18'sd131072, 12'd319, 24'h006400, 1'b0);

        // drop enable mid-divide: result still completes, re-enable flushes
        repeat (8) @(negedge sys_clk);
        bus.meas_enable = 1'b0;
        repeat (120) @(negedge sys_clk);
        bus.meas_enable = 1'b1;
        wait_clear();
        repeat (2) @(negedge sys_clk);

        window(40'd5000, 30'd0, 36'hA_AAAA_AAAA, 18'sd131071, 12'd767, 24'hFF_FFFF, 1'b1);
        window(40'd1000, 30'd1000, 36'h5_5555_5555, 18'sd0, 12'd0, 24'h000100, 1'b0);
        window(40'd1000000, 30'd7, 36'h0_0000_0007, 18'sd7, 12'd767, 24'hFF_FFFF, 1'b0);
        window(40'd1, 30'd1000, 36'h0_0000_0100, -18'sd1, 12'd0, 24'h000000, 1'b0);
        window(40'd5, 30'd4, 36'h0_0000_0140, 18'sd320, 12'd15, 24'h000140, 1'b0);
        window(40'hFF_FFFF_FFFF, 30'h3FFF_FFFF, 36'hF_FFFF_FFFF, -18'sd100, 12'd481, 24'h040000, 1'b0);
        window(40'd5000, 30'd0, 36'h3_3333_3333, 18'sd42, 12'd767, 24'hFF_FFFF, 1'b1);

        // reset during DIVIDE: aborted, nothing reported
        set_inputs(40'd100000, 30'd1000, 36'h7_7777_7777, 18'sd77);
        wait_clear();
        repeat (20) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        chk_reset_state("rst_mid");
        reset   = 1'b1;
        exp_min = 12'hFFF;

        window(40'd1000, 30'd1000, 36'h8_8888_8888, -18'sd88, 12'd0, 24'h000100, 1'b0);

        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge sys_clk);
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (10) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
